// File: rtl/max_sel_ctrl.sv
// max_sel_ctrl: sweeps four selector channels in turn. For each channel it
// loads that channel's decimation count and gain, holds sync_n low for a
// short frame-sync window, then collects a fixed number of selector results
// into a small tagged FIFO that a downstream consumer drains.
module max_sel_ctrl #(
    parameter int SYNC_LEN   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [1:0] cfg_ch,
    input  logic [7:0] cfg_smax,
    input  logic [5:0] cfg_mul,
    input  logic [7:0] pts_num,
    input  logic       start,
    input  logic       abort,
    output logic       sync_n,
    output logic [7:0] smax_num,
    output logic [5:0] mul_c,
    output logic [1:0] ch_sel,
    input  logic [7:0] mx_data,
    input  logic       mx_valid,
    output logic [7:0] out_data,
    output logic [1:0] out_ch,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       SYNC_LAST = 4'(SYNC_LEN - 1);

    typedef enum logic [2:0] {IDLE, SYNC, RUN, NEXT, DONE} state_t;

    state_t state, state_next;

    logic [1:0] ch, ch_next;
    logic [3:0] sync_cnt;
    logic [8:0] pts_cnt, pts_cnt_inc, pts_target;
    logic       sweep_go, sync_entry;

    logic [7:0] slot_smax [4];
    logic [5:0] slot_mul  [4];

    logic [9:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0] fifo_cnt, fifo_cnt_next;
    logic             push, pop, fifo_full, do_write, drop, head_from_write;

    assign pts_cnt_inc = pts_cnt + 9'd1;
    assign sweep_go    = (state == IDLE) && (state_next == SYNC);
    assign sync_entry  = (state_next == SYNC) && (state != SYNC);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and state-decoded outputs.
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        ch_next    = ch;
        sync_n     = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    state_next = SYNC;
                    ch_next    = 2'd0;
                end
            end
            SYNC: begin
                sync_n = 1'b0;
                if (sync_cnt == SYNC_LAST) state_next = RUN;
            end
            RUN: begin
                if (mx_valid && (pts_cnt_inc == pts_target)) state_next = NEXT;
            end
            NEXT: begin
                sync_n = 1'b0;
                if (ch == 2'd3) begin
                    state_next = DONE;
                end else begin
                    state_next = SYNC;
                    ch_next    = ch + 2'd1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides every transition but cannot resurrect an idle controller.
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            ch_next    = ch;
        end
    end

    // Sweep bookkeeping: channel index, counters, per-channel output latch, overflow flag.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            ch         <= 2'd0;
            sync_cnt   <= 4'd0;
            pts_cnt    <= 9'd0;
            pts_target <= 9'd0;
            smax_num   <= 8'd0;
            mul_c      <= 6'd0;
            ch_sel     <= 2'd0;
            ovf        <= 1'b0;
        end else begin
            ch <= ch_next;
            // A pts_num of zero encodes 256 through the ninth bit.
            if (sweep_go) pts_target <= {pts_num == 8'd0, pts_num};
            // Channel settings freeze at SYNC entry so later config writes wait for the next channel.
            if (sync_entry) begin
                smax_num <= slot_smax[ch_next];
                mul_c    <= slot_mul[ch_next];
                ch_sel   <= ch_next;
            end
            sync_cnt <= (state == SYNC) ? sync_cnt + 4'd1 : 4'd0;
            if (state != RUN)  pts_cnt <= 9'd0;
            else if (mx_valid) pts_cnt <= pts_cnt_inc;
            if (sweep_go)  ovf <= 1'b0;
            else if (drop) ovf <= 1'b1;
        end
    end

    // Config slots, writable in any state.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                slot_smax[i] <= 8'd0;
                slot_mul[i]  <= 6'd0;
            end
        end else if (cfg_we) begin
            slot_smax[cfg_ch] <= cfg_smax;
            slot_mul[cfg_ch]  <= cfg_mul;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves in the same cycle.
    assign push            = (state == RUN) && mx_valid;
    assign pop             = (fifo_cnt != '0) && out_ready;
    assign fifo_full       = (fifo_cnt == FULL_CNT);
    assign do_write        = push && (!fifo_full || pop);
    assign drop            = push && fifo_full && !pop;
    assign rd_ptr_next     = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign head_from_write = do_write && (wr_ptr == rd_ptr_next);
    assign out_valid       = (fifo_cnt != '0);

    // Occupancy next value.
    always_comb begin
        fifo_cnt_next = fifo_cnt;
        case ({do_write, pop})
            2'b10:   fifo_cnt_next = fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt_next = fifo_cnt - CNT_W'(1);
            default: fifo_cnt_next = fifo_cnt;
        endcase
    end

    // FIFO storage.
    // NOTE: the data array has no reset; emptiness is carried by the pointers and count alone.
    always_ff @(posedge sysclk) begin
        if (do_write) fifo_mem[wr_ptr] <= {ch, mx_data};
    end

    // FIFO pointers, count and the registered head; the head holds its value once empty.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            out_data <= 8'd0;
            out_ch   <= 2'd0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr   <= rd_ptr_next;
            fifo_cnt <= fifo_cnt_next;
            if (fifo_cnt_next != '0) begin
                if (head_from_write) {out_ch, out_data} <= {ch, mx_data};
                else                 {out_ch, out_data} <= fifo_mem[rd_ptr_next];
            end
        end
    end

endmodule
